// File: rtl/lo_phase_sync.sv
// lo_phase_sync: checks the sampled LO quadrant against an accumulator prediction, requests divider slips, flags LOCK.
// Decision lands WIN+1 cycles after ACQ entry; no backpressure, SLIP_REQ is a one-cycle pulse the divider must honour within SETTLE.
module lo_phase_sync #(
   parameter int FCW_F    = 16,
   parameter int WIN_LOG2 = 4,
   parameter int LOCK_CNT = 4,
   parameter int SETTLE   = 4
) (
   input  logic                       REF,
   input  logic                       NARST,
   input  logic                       EN,
   input  logic [FCW_F-1:0]           FCW_LO,
   input  logic [1:0]                 LO_STATE,
   output logic [1:0]                 PH_OFS,
   output logic                       SLIP_REQ,
   output logic [1:0]                 SLIP_Q,
   output logic signed [WIN_LOG2+2:0] PH_ERR,
   output logic                       AMB,
   output logic                       LOCK
);

   localparam int WIN  = 1 << WIN_LOG2;
   localparam int SW   = WIN_LOG2 + 3;
   localparam int SETW = $clog2(SETTLE + 1);
   localparam int LCW  = $clog2(LOCK_CNT + 1);

   localparam logic signed [SW-1:0] QTR   = SW'(WIN / 4);
   localparam logic signed [SW-1:0] HALF  = SW'(WIN / 2);
   localparam logic signed [SW-1:0] Q_MAX = SW'(1);
   localparam logic signed [SW-1:0] Q_MIN = SW'(-2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACQ,
      S_DECIDE,
      S_SETTLE
   } state_t;

   state_t                   state_q, state_d;
   logic [FCW_F-1:0]         acc_q, acc_d;
   logic [1:0]               acc_d1_q, acc_d1_d;
   logic signed [SW-1:0]     s_q, s_d;
   logic [WIN_LOG2-1:0]      win_cnt_q, win_cnt_d;
   logic [SETW-1:0]          set_cnt_q, set_cnt_d;
   logic [LCW-1:0]           clean_cnt_q, clean_cnt_d;
   logic [1:0]               ph_ofs_q, ph_ofs_d;
   logic                     slip_req_q, slip_req_d;
   logic [1:0]               slip_q_q, slip_q_d;
   logic signed [SW-1:0]     ph_err_q, ph_err_d;
   logic                     amb_q, amb_d;
   logic                     lock_q, lock_d;

   logic [1:0]               qm;
   logic [1:0]               qe;
   logic [1:0]               e_raw;
   logic signed [SW-1:0]     e_val;
   logic                     win_clean;
   logic signed [SW-1:0]     s_rnd;
   logic signed [SW-1:0]     q_full;
   logic [1:0]               q_sel;

   // Sample error datapath; the 2-bit modular difference read as two's complement is exactly the 0/+1/-2/-1 mapping.
   always_comb begin
      qm = 2'd3;
      case (LO_STATE)
         2'b10:   qm = 2'd0;
         2'b11:   qm = 2'd1;
         2'b01:   qm = 2'd2;
         default: qm = 2'd3;
      endcase
      qe    = acc_d1_q + ph_ofs_q;
      e_raw = qm - qe;
      e_val = {{(SW-2){e_raw[1]}}, e_raw};
   end

   // Window decision: rounded quadrant estimate, clamped to the representable slip range.
   always_comb begin
      win_clean = (s_q <= QTR) && (s_q >= -QTR);
      s_rnd     = s_q + HALF;
      q_full    = s_rnd >>> WIN_LOG2;
      q_sel     = q_full[1:0];
      if (q_full > Q_MAX) begin
         q_sel = 2'b01;
      end else if (q_full < Q_MIN) begin
         q_sel = 2'b10;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      acc_d1_d    = acc_d1_q;
      s_d         = s_q;
      win_cnt_d   = win_cnt_q;
      set_cnt_d   = set_cnt_q;
      clean_cnt_d = clean_cnt_q;
      ph_ofs_d    = ph_ofs_q;
      slip_req_d  = 1'b0;
      slip_q_d    = 2'b00;
      ph_err_d    = ph_err_q;
      amb_d       = amb_q;
      lock_d      = lock_q;

      if (!EN || state_q == S_IDLE) begin
         state_d     = EN ? S_ACQ : S_IDLE;
         acc_d       = '0;
         acc_d1_d    = '0;
         s_d         = '0;
         win_cnt_d   = '0;
         set_cnt_d   = '0;
         clean_cnt_d = '0;
         ph_ofs_d    = '0;
         ph_err_d    = '0;
         amb_d       = 1'b0;
         lock_d      = 1'b0;
      end else begin
         // Only the quadrant bits of the delayed accumulator feed the prediction.
         acc_d    = acc_q + FCW_LO;
         acc_d1_d = acc_q[FCW_F-1 -: 2];

         case (state_q)
            S_ACQ: begin
               s_d       = s_q + e_val;
               amb_d     = amb_q | (e_raw == 2'b10);
               win_cnt_d = win_cnt_q + 1'b1;
               if (win_cnt_q == WIN_LOG2'(WIN - 1)) begin
                  win_cnt_d = '0;
                  state_d   = S_DECIDE;
               end
            end

            S_DECIDE: begin
               ph_err_d = s_q;
               s_d      = '0;
               if (win_clean) begin
                  if (clean_cnt_q != LCW'(LOCK_CNT)) begin
                     clean_cnt_d = clean_cnt_q + 1'b1;
                  end
                  lock_d  = (clean_cnt_d == LCW'(LOCK_CNT));
                  state_d = S_ACQ;
               end else if (q_sel != 2'b00) begin
                  ph_ofs_d    = ph_ofs_q + q_sel;
                  slip_req_d  = 1'b1;
                  slip_q_d    = q_sel;
                  lock_d      = 1'b0;
                  clean_cnt_d = '0;
                  set_cnt_d   = '0;
                  state_d     = S_SETTLE;
               end else begin
                  lock_d      = 1'b0;
                  clean_cnt_d = '0;
                  state_d     = S_ACQ;
               end
            end

            // SETTLE discarded samples plus one re-entry edge, mirroring IDLE->ACQ.
            S_SETTLE: begin
               if (set_cnt_q == SETW'(SETTLE)) begin
                  set_cnt_d = '0;
                  state_d   = S_ACQ;
               end else begin
                  set_cnt_d = set_cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge REF or negedge NARST) begin
      if (!NARST) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         acc_d1_q    <= '0;
         s_q         <= '0;
         win_cnt_q   <= '0;
         set_cnt_q   <= '0;
         clean_cnt_q <= '0;
         ph_ofs_q    <= '0;
         slip_req_q  <= 1'b0;
         slip_q_q    <= '0;
         ph_err_q    <= '0;
         amb_q       <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         acc_d1_q    <= acc_d1_d;
         s_q         <= s_d;
         win_cnt_q   <= win_cnt_d;
         set_cnt_q   <= set_cnt_d;
         clean_cnt_q <= clean_cnt_d;
         ph_ofs_q    <= ph_ofs_d;
         slip_req_q  <= slip_req_d;
         slip_q_q    <= slip_q_d;
         ph_err_q    <= ph_err_d;
         amb_q       <= amb_d;
         lock_q      <= lock_d;
      end
   end

   assign PH_OFS   = ph_ofs_q;
   assign SLIP_REQ = slip_req_q;
   assign SLIP_Q   = slip_q_q;
   assign PH_ERR   = ph_err_q;
   assign AMB      = amb_q;
   assign LOCK     = lock_q;

endmodule

// File: tb/tb_lo_phase_sync.sv
// Directed bench for lo_phase_sync: LO model driven from the reference accumulator trajectory, window results scoreboarded.
module tb_lo_phase_sync;

   localparam int FCW_F    = 16;
   localparam int WIN_LOG2 = 4;
   localparam int LOCK_CNT = 4;
   localparam int SETTLE   = 4;
   localparam int WIN      = 1 << WIN_LOG2;
   localparam int FCW_I    = 'h2000;

   logic              ref_clk;
   logic              narst;
   logic              en;
   logic [FCW_F-1:0]  fcw_lo;
   logic [1:0]        lo_state;
   logic [1:0]        ph_ofs;
   logic              slip_req;
   logic [1:0]        slip_q;
   logic signed [6:0] ph_err;
   logic              amb;
   logic              lock;

   typedef struct {
      int         s;
      logic       slip;
      logic [1:0] q;
      logic [1:0] ofs;
      logic       lock;
      logic       amb;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   n;
   int   m_ofs;
   int   m_cc;
   logic m_lock;
   logic m_amb;

   lo_phase_sync #(
      .FCW_F    (FCW_F),
      .WIN_LOG2 (WIN_LOG2),
      .LOCK_CNT (LOCK_CNT),
      .SETTLE   (SETTLE)
   ) dut (
      .REF      (ref_clk),
      .NARST    (narst),
      .EN       (en),
      .FCW_LO   (fcw_lo),
      .LO_STATE (lo_state),
      .PH_OFS   (ph_ofs),
      .SLIP_REQ (slip_req),
      .SLIP_Q   (slip_q),
      .PH_ERR   (ph_err),
      .AMB      (amb),
      .LOCK     (lock)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500000");
      $fatal(1);
   end

   function automatic logic [1:0] enc(input int q);
      case (q & 3)
         0:       return 2'b10;
         1:       return 2'b11;
         2:       return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Quadrant of the accumulator value the DUT predicts with at edge k after ACQ entry.
   function automatic int pred_quad(input int k);
      int a;
      a = (k < 2) ? 0 : (k - 2) * FCW_I;
      return (a >> 14) & 3;
   endfunction

   function automatic logic [15:0] rand_mask(input int k);
      logic [15:0] m;
      m = '0;
      while ($countones(m) < k) m[$urandom_range(15, 0)] = 1'b1;
      return m;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int d);
      @(negedge ref_clk);
      lo_state = enc(pred_quad(n + 1) + d);
      @(posedge ref_clk);
      n++;
      #1;
   endtask

   task automatic model_clear();
      n      = 0;
      m_ofs  = 0;
      m_cc   = 0;
      m_lock = 1'b0;
      m_amb  = 1'b0;
      sb.delete();
   endtask

   task automatic restart();
      en = 1'b0;
      tick(0);
      en = 1'b1;
      tick(0);
      model_clear();
   endtask

   task automatic run_window(input int d_base, input logic [15:0] mask, input int d_alt, input bit do_settle);
      int   s;
      int   d;
      int   er;
      int   q;
      exp_t x;
      s = 0;
      for (int i = 0; i < WIN; i++) begin
         d = mask[i] ? d_alt : d_base;
         tick(d);
         er = (d - m_ofs) & 3;
         if (er == 2) m_amb = 1'b1;
         s += (er == 0) ? 0 : (er == 1) ? 1 : (er == 2) ? -2 : -1;
      end
      x.s    = s;
      x.slip = 1'b0;
      x.q    = 2'b00;
      if (s <= WIN / 4 && s >= -(WIN / 4)) begin
         if (m_cc < LOCK_CNT) m_cc++;
         m_lock = (m_cc == LOCK_CNT);
      end else begin
         q = (s + WIN / 2) >>> WIN_LOG2;
         if (q > 1) q = 1;
         if (q < -2) q = -2;
         m_lock = 1'b0;
         m_cc   = 0;
         if (q != 0) begin
            x.slip = 1'b1;
            x.q    = q[1:0];
            m_ofs  = (m_ofs + q) & 3;
         end
      end
      x.ofs  = m_ofs[1:0];
      x.lock = m_lock;
      x.amb  = m_amb;
      sb.push_back(x);
      tick(d_base);
      x = sb.pop_front();
      check("ph_err", ph_err, x.s);
      check("slip_req", slip_req, x.slip);
      check("slip_q", slip_q, x.q);
      check("ph_ofs", ph_ofs, x.ofs);
      check("lock", lock, x.lock);
      check("amb", amb, x.amb);
      if (x.slip && do_settle) begin
         tick(d_base);
         check("slip_req_width", slip_req, 0);
         repeat (SETTLE) tick(d_base);
      end
   endtask

   initial begin
      narst    = 1'b0;
      en       = 1'b0;
      fcw_lo   = FCW_F'(FCW_I);
      lo_state = 2'b10;
      model_clear();
      #12;
      check("rst_ph_ofs", ph_ofs, 0);
      check("rst_slip_req", slip_req, 0);
      check("rst_slip_q", slip_q, 0);
      check("rst_ph_err", ph_err, 0);
      check("rst_amb", amb, 0);
      check("rst_lock", lock, 0);
      @(negedge ref_clk);
      narst = 1'b1;

      // Aligned LO: four clean windows, LOCK on the fourth decision.
      restart();
      repeat (4) run_window(0, 16'h0000, 0, 1'b1);
      check("aligned_lock_cycle", n, 4 * (WIN + 1));

      // +1 quadrant: one slip, then lock.
      restart();
      repeat (5) run_window(1, 16'h0000, 0, 1'b1);

      // +2 quadrants: ambiguous, slip by -2, then lock.
      restart();
      repeat (5) run_window(2, 16'h0000, 0, 1'b1);

      // EN low for one cycle clears everything, then reacquire.
      en = 1'b0;
      tick(2);
      check("endrop_lock", lock, 0);
      check("endrop_ph_ofs", ph_ofs, 0);
      check("endrop_amb", amb, 0);
      check("endrop_ph_err", ph_err, 0);
      en = 1'b1;
      tick(0);
      model_clear();
      repeat (4) run_window(0, 16'h0000, 0, 1'b1);

      // -1 slip wraps PH_OFS 0->3, then +1 wraps 3->0.
      run_window(3, 16'h0000, 0, 1'b1);
      run_window(0, 16'h0000, 0, 1'b1);

      // Relock, then a window with S=6 rounds to q=0: lock lost, no slip.
      repeat (4) run_window(0, 16'h0000, 0, 1'b1);
      run_window(0, rand_mask(6), 1, 1'b1);

      // +1 with a quarter of samples clean: S=12, still slips +1.
      restart();
      run_window(1, rand_mask(4), 0, 1'b1);
      // 3 of 16 samples off by one: clean.
      run_window(1, rand_mask(3), 2, 1'b1);

      // Reset asserted during SETTLE while SLIP_REQ is high.
      restart();
      run_window(1, 16'h0000, 0, 1'b0);
      #2;
      narst = 1'b0;
      #1;
      check("arst_slip_req", slip_req, 0);
      check("arst_slip_q", slip_q, 0);
      check("arst_ph_ofs", ph_ofs, 0);
      check("arst_ph_err", ph_err, 0);
      check("arst_lock", lock, 0);
      check("arst_amb", amb, 0);
      @(posedge ref_clk);
      #1;
      check("arst_hold_slip_req", slip_req, 0);
      @(negedge ref_clk);
      narst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
